sub_share_arbiter: RTL and testbench
====================================

// Module: sub_share_arbiter
// PURPOSE
//   Round-robin arbiter/sequencer sharing one SUB datapath unit among NUM_REQ requesters.
//   Grants one request at a time, latches that requester's operands and computes A - B.
//   Returns a registered difference, borrow flag and winner ID, and pulses the winner's Done.
//   Sits between scheduled datapath consumers and a single SUB instance (#(DATAWIDTH)).
// PARAMETERS
//   DATAWIDTH  8  operand/result width in bits
//   NUM_REQ    4  number of requesters, legal range 2..16
//   IDW        derived, max(1,$clog2(NUM_REQ)); width of GntId (not user-set)
// PORTS
//   Clk     in   1                  rising-edge clock
//   Rst     in   1                  asynchronous reset, active-low
//   Req     in   NUM_REQ            Req[i]=1: requester i has an operation pending
//   A_bus   in   NUM_REQ*DATAWIDTH  minuend of requester i at [i*DATAWIDTH +: DATAWIDTH]
//   B_bus   in   NUM_REQ*DATAWIDTH  subtrahend of requester i, same packing
//   Gnt     out  NUM_REQ            one-hot; 1-cycle pulse, operands of winner captured
//   Done    out  NUM_REQ            one-hot; 1-cycle pulse, Diff/Borrow valid for winner
//   GntId   out  IDW                index of the most recent winner; held until next grant
//   Diff    out  DATAWIDTH          registered A - B of the last completed op; held
//   Borrow  out  1                  1 when A < B (unsigned) for the last op; held
//   Busy    out  1                  1 while in EXEC
// BEHAVIOUR
//   Reset (Rst=0, async): state=IDLE, ptr=0, opA/opB=0, Gnt=0, Done=0, GntId=0,
//     Diff=0, Borrow=0, Busy=0. Reset mid-EXEC discards the op; no Done follows release.
//   FSM, 2 states; all outputs are registered:
//     IDLE: Done<=0. If Req==0, stay. Else winner w = first set Req bit, searching
//       ptr, ptr+1, ... mod NUM_REQ. Latch opA/opB from slot w, Gnt<=onehot(w), GntId<=w,
//       ptr<=(w+1) mod NUM_REQ, Busy<=1, go to EXEC.
//     EXEC: Req is ignored. Diff<=opA-opB (SUB output), Borrow<=(opA<opB),
//       Done<=onehot(GntId), Gnt<=0, Busy<=0, go to IDLE.
//   Timing: Req high at edge k (IDLE) -> Gnt high cycle k..k+1 -> Diff/Borrow/Done
//     valid cycle k+1..k+2. Throughput is 1 op per 2 cycles; back-to-back grant at edge k+2.
//   Handshake: requester holds Req and operands stable until it sees Gnt[i], then
//     deasserts Req by the next edge. Req still high in a later IDLE is a new request.
//   Arithmetic: unsigned, modulo 2^DATAWIDTH. Wrap-around gives Borrow=1 and
//     Diff = A - B + 2^DATAWIDTH. A==B gives Diff=0, Borrow=0.
//   Operand changes after capture do not affect the in-flight result.
//   Fairness: a continuously asserted requester waits at most NUM_REQ-1 grants.
//   Simultaneous Req bits are resolved by ptr only. Bits of Req above NUM_REQ-1 do not exist.
// TESTING
//   1 Rst=0 during EXEC (after Gnt=0001) -> all outputs 0 at once; no Done after release.
//   2 Req=0001, A0=20, B0=5 -> Gnt=0001 next cycle, then Done=0001, Diff=15, Borrow=0, GntId=0.
//   3 Req=0010, A1=5, B1=20 (DATAWIDTH=8) -> Diff=8'hF1, Borrow=1, Done=0010.
//   4 Req=1111 held, each bit dropped after its Gnt -> grant order 0,1,2,3 at 2-cycle
//     spacing; Done order identical; Busy toggles 1,0,1,0.
//   5 Req0 re-asserted after every grant, Req2 raised during op0 -> next grant is 2,
//     then 0 again; no requester is starved.
//   6 Req3 raised in EXEC, A3=B3=8'hFF -> no grant until the following IDLE edge;
//     then Diff=0, Borrow=0, GntId=3.

Source files
------------

// File: rtl/sub_share_arbiter.sv
// rtl/sub_share_arbiter.sv - round-robin sequencer sharing one subtractor among NUM_REQ requesters
//
// Grants one pending requester at a time, captures its operands, and one cycle
// later returns the registered difference, borrow flag and a Done pulse.
//
// Ports:
//   Clk     rising-edge clock
//   Rst     asynchronous reset, active-low
//   Req     per-requester pending operation
//   A_bus   packed minuends, requester i at [i*DATAWIDTH +: DATAWIDTH]
//   B_bus   packed subtrahends, same packing
//   Gnt     one-hot 1-cycle pulse: winner's operands captured
//   Done    one-hot 1-cycle pulse: Diff/Borrow valid for winner
//   GntId   index of most recent winner, held until next grant
//   Diff    A - B (modulo 2^DATAWIDTH) of last completed op, held
//   Borrow  1 when A < B (unsigned) for last completed op, held
//   Busy    1 while the shared subtractor holds an operation
module sub_share_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int NUM_REQ   = 4,
    localparam int IDW      = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ)
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic [NUM_REQ-1:0]             Req,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   A_bus,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   B_bus,
    output logic [NUM_REQ-1:0]             Gnt,
    output logic [NUM_REQ-1:0]             Done,
    output logic [IDW-1:0]                 GntId,
    output logic [DATAWIDTH-1:0]           Diff,
    output logic                           Borrow,
    output logic                           Busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [IDW-1:0]         ptr_q, ptr_d;
    logic [DATAWIDTH-1:0]   opa_q, opa_d;
    logic [DATAWIDTH-1:0]   opb_q, opb_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic [IDW-1:0]         gntid_q, gntid_d;
    logic [DATAWIDTH-1:0]   diff_q, diff_d;
    logic                   borrow_q, borrow_d;
    logic                   busy_q, busy_d;

    logic                   found;
    logic [IDW-1:0]         cand;
    logic [IDW-1:0]         win;
    logic [DATAWIDTH:0]     sub_full;

    // Rotating priority search: walk ptr, ptr+1, ... and take the first set bit.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && Req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Shared subtractor; the extra MSB of the widened difference is the borrow.
    assign sub_full = {1'b0, opa_q} - {1'b0, opb_q};

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        gnt_d    = '0;
        done_d   = '0;
        gntid_d  = gntid_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        busy_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    opa_d   = A_bus[int'(win)*DATAWIDTH +: DATAWIDTH];
                    opb_d   = B_bus[int'(win)*DATAWIDTH +: DATAWIDTH];
                    gnt_d   = NUM_REQ'(1) << win;
                    gntid_d = win;
                    ptr_d   = (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);
                    busy_d  = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                diff_d   = sub_full[DATAWIDTH-1:0];
                borrow_d = sub_full[DATAWIDTH];
                done_d   = NUM_REQ'(1) << gntid_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            gntid_q  <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            gntid_q  <= gntid_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
        end
    end

    assign Gnt    = gnt_q;
    assign Done   = done_q;
    assign GntId  = gntid_q;
    assign Diff   = diff_q;
    assign Borrow = borrow_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_sub_share_arbiter.sv
// tb/tb_sub_share_arbiter.sv - scoreboard bench for sub_share_arbiter
module tb_sub_share_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;

    logic            Clk;
    logic            Rst;
    logic [NR-1:0]   Req;
    logic [NR*DW-1:0] A_bus;
    logic [NR*DW-1:0] B_bus;
    logic [NR-1:0]   Gnt;
    logic [NR-1:0]   Done;
    logic [1:0]      GntId;
    logic [DW-1:0]   Diff;
    logic            Borrow;
    logic            Busy;

    sub_share_arbiter #(.DATAWIDTH(DW), .NUM_REQ(NR)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .A_bus(A_bus), .B_bus(B_bus),
        .Gnt(Gnt), .Done(Done), .GntId(GntId), .Diff(Diff),
        .Borrow(Borrow), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int            id;
        logic [DW-1:0] diff;
        logic          borrow;
    } res_t;

    int   exp_gnt[$];
    res_t exp_res[$];

    int n_checks = 0;
    int n_fail   = 0;

    // requester-side state
    logic [NR-1:0] req;
    logic [NR-1:0] sticky;
    logic [DW-1:0] a [NR];
    logic [DW-1:0] b [NR];
    int  model_ptr;
    bit  model_busy;
    bit  drop_pending;
    int  drop_id;

    // monitor-side state
    logic [DW-1:0] last_diff;
    logic          last_borrow;
    int            last_id;
    int            mon_wait;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] rand_op();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            default: return DW'($urandom);
        endcase
    endfunction

    // Next falling edge; a requester granted last cycle withdraws (or re-arms if sticky).
    task automatic next_cycle();
        @(negedge Clk);
        if (drop_pending) begin
            if (sticky[drop_id]) begin
                a[drop_id] = rand_op();
                b[drop_id] = rand_op();
            end else begin
                req[drop_id] = 1'b0;
            end
            drop_pending = 1'b0;
        end
    endtask

    // Drive the requester state and predict what the arbiter will do at the next edge.
    task automatic commit();
        int w;
        int idx;
        res_t r;
        for (int i = 0; i < NR; i++) begin
            A_bus[i*DW +: DW] = a[i];
            B_bus[i*DW +: DW] = b[i];
        end
        Req = req;
        if (model_busy) begin
            model_busy = 1'b0;
        end else if (req != '0) begin
            w = -1;
            for (int k = 0; k < NR; k++) begin
                idx = (model_ptr + k) % NR;
                if (w < 0 && req[idx]) w = idx;
            end
            r.id     = w;
            r.diff   = DW'((int'(a[w]) - int'(b[w]) + 256) % 256);
            r.borrow = (a[w] < b[w]);
            exp_gnt.push_back(w);
            exp_res.push_back(r);
            model_ptr    = (w + 1) % NR;
            model_busy   = 1'b1;
            drop_pending = 1'b1;
            drop_id      = w;
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin
            next_cycle();
            commit();
        end
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_gnt"},    Gnt, 0);
        chk({tag, "_done"},   Done, 0);
        chk({tag, "_gntid"},  GntId, 0);
        chk({tag, "_diff"},   Diff, 0);
        chk({tag, "_borrow"}, Borrow, 0);
        chk({tag, "_busy"},   Busy, 0);
    endtask

    task automatic flush_model();
        exp_gnt.delete();
        exp_res.delete();
        model_ptr    = 0;
        model_busy   = 1'b0;
        drop_pending = 1'b0;
        req          = '0;
        sticky       = '0;
        Req          = '0;
        last_diff    = '0;
        last_borrow  = 1'b0;
        last_id      = 0;
        mon_wait     = 0;
    endtask

    always @(negedge Clk) begin
        int   g;
        res_t r;
        if (Rst) begin
            if (Gnt != '0) begin
                if (exp_gnt.size() == 0) begin
                    chk("unexpected_gnt", Gnt, 0);
                end else begin
                    g = exp_gnt.pop_front();
                    chk("gnt", Gnt, 1 << g);
                    chk("gnt_id", GntId, g);
                    chk("busy_exec", Busy, 1);
                    last_id = g;
                end
            end else begin
                chk("busy_idle", Busy, 0);
                chk("gntid_hold", GntId, last_id);
            end
            if (Done != '0) begin
                if (exp_res.size() == 0) begin
                    chk("unexpected_done", Done, 0);
                end else begin
                    r = exp_res.pop_front();
                    chk("done", Done, 1 << r.id);
                    chk("diff", Diff, r.diff);
                    chk("borrow", Borrow, r.borrow);
                    chk("done_id", GntId, r.id);
                    last_diff   = r.diff;
                    last_borrow = r.borrow;
                    mon_wait    = 0;
                end
            end else begin
                chk("diff_hold", Diff, last_diff);
                chk("borrow_hold", Borrow, last_borrow);
                if (exp_res.size() > 0) begin
                    mon_wait++;
                    if (mon_wait > 3) begin
                        chk("done_timeout", mon_wait, 3);
                        r = exp_res.pop_front();
                        mon_wait = 0;
                    end
                end
            end
        end
    end

    initial begin
        Rst   = 1'b0;
        A_bus = '0;
        B_bus = '0;
        for (int i = 0; i < NR; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        flush_model();
        #3;
        check_reset_outputs("por");
        @(posedge Clk);
        #2 Rst = 1'b1;

        // single request, no borrow
        next_cycle();
        req[0] = 1'b1; a[0] = 8'd20; b[0] = 8'd5;
        commit();
        idle(4);

        // wrap-around with borrow
        next_cycle();
        req[1] = 1'b1; a[1] = 8'd5; b[1] = 8'd20;
        commit();
        idle(4);

        // reset while an op is in flight
        next_cycle();
        req[0] = 1'b1; a[0] = 8'd77; b[0] = 8'd3;
        commit();
        @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        check_reset_outputs("mid_exec_rst");
        flush_model();
        @(posedge Clk);
        #2 Rst = 1'b1;
        idle(4);

        // all four at once: rotation from a freshly reset pointer
        next_cycle();
        req = 4'hF;
        for (int i = 0; i < NR; i++) begin
            a[i] = rand_op();
            b[i] = rand_op();
        end
        commit();
        idle(10);

        // requester 0 keeps re-arming, requester 2 joins during op0
        next_cycle();
        sticky[0] = 1'b1; req[0] = 1'b1; a[0] = 8'd9; b[0] = 8'd4;
        commit();
        next_cycle();
        req[2] = 1'b1; a[2] = rand_op(); b[2] = rand_op();
        commit();
        idle(8);
        next_cycle();
        sticky = '0;
        commit();
        idle(4);

        // request raised while EXEC is in progress
        next_cycle();
        req[0] = 1'b1; a[0] = 8'd1; b[0] = 8'd2;
        commit();
        next_cycle();
        req[3] = 1'b1; a[3] = 8'hFF; b[3] = 8'hFF;
        commit();
        idle(6);

        // randomized traffic
        repeat (400) begin
            next_cycle();
            for (int i = 0; i < NR; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    a[i]   = rand_op();
                    b[i]   = ($urandom_range(0, 7) == 0) ? a[i] : rand_op();
                end
            end
            commit();
        end
        next_cycle();
        req = '0;
        commit();
        idle(12);

        chk("drain_gnt", exp_gnt.size(), 0);
        chk("drain_res", exp_res.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
